// File: rtl/csa_mult_seq_pkg.sv
// Shared definitions for the sequential carry-save multiplier.
//   state_t       : FSM state encoding (IDLE, ACCUM, RESOLVE, DONE)
//   DEFAULT_WIDTH : default operand width in bits
package csa_mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/csa_mult_seq_csa_row.sv
// One row of 3:2 carry-save compressors.
//   a, b, c : N-bit addends
//   sum     : bitwise XOR of the three addends
//   carry   : bitwise majority shifted left by one (bit 0 low, MSB carry dropped)
// a + b + c == sum + carry (mod 2^N)
module csa_row #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  logic [N-1:0] maj;

  always_comb begin
    sum   = a ^ b ^ c;
    maj   = (a & b) | (a & c) | (b & c);
    carry = {maj[N-2:0], 1'b0};
  end

endmodule

// File: rtl/csa_mult_seq.sv
// Sequential unsigned multiplier: one partial product per cycle folded into a
// redundant sum/carry pair by a single CSA row, resolved by one adder at the end.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   a_op, b_op          : WIDTH-bit unsigned operands
//   out_valid/out_ready : product handshake (out_valid only in DONE)
//   product             : 2*WIDTH-bit unsigned product, held stable in DONE
//   busy                : high in every state except IDLE
// Latency: WIDTH+1 edges from acceptance to out_valid.
module csa_mult_seq
  import csa_mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_op,
  input  logic [WIDTH-1:0]     b_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned KW = $clog2(WIDTH);

  state_t          state;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [PW-1:0]   sum_r;
  logic [PW-1:0]   carry_r;
  logic [KW-1:0]   k;
  logic [PW-1:0]   row_c;
  logic [PW-1:0]   row_sum;
  logic [PW-1:0]   row_carry;

  // Partial product for bit k of the multiplier.
  always_comb begin
    row_c = '0;
    if (b_lat[k]) row_c = {{WIDTH{1'b0}}, a_lat} << k;
  end

  csa_row #(.N(PW)) u_row (
    .a     (sum_r),
    .b     (carry_r),
    .c     (row_c),
    .sum   (row_sum),
    .carry (row_carry)
  );

  // Handshake/status outputs are registered alongside the state so they never
  // depend combinationally on any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      sum_r     <= '0;
      carry_r   <= '0;
      k         <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_lat    <= a_op;
            b_lat    <= b_op;
            sum_r    <= '0;
            carry_r  <= '0;
            k        <= '0;
            state    <= ACCUM;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          sum_r   <= row_sum;
          carry_r <= row_carry;
          k       <= k + KW'(1);
          if (k == KW'(WIDTH - 1)) state <= RESOLVE;
        end
        RESOLVE: begin
          product   <= sum_r + carry_r;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_mult_seq.sv
// Self-checking bench for csa_mult_seq at WIDTH=32: directed vector table,
// hand-written handshake/reset sequences and a random run against a native
// 64-bit multiply.
module tb_csa_mult_seq;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_op;
  logic [W-1:0]  b_op;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] product;
  logic          busy;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[10];

  csa_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_op      (a_op),
    .b_op      (b_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int i;
    i = 0;
    while (!in_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    ok = in_ready;
    if (!ok) return;
    a_op = a;
    b_op = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_op = $urandom;
    b_op = $urandom;
  endtask

  // Counts edges after acceptance until out_valid is seen (100 = timeout).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] p, output int lat);
    bit ok;
    accept_op(a, b, ok);
    if (!ok) begin
      lat = -1;
      p = 'x;
      return;
    end
    wait_valid(lat);
    p = product;
    release_out();
  endtask

  initial begin
    logic [2*W-1:0] p;
    logic [2*W-1:0] exp;
    logic [W-1:0]   ra, rb;
    int  lat;
    bit  ok;
    bit  bad;
    int  acc_edge[2];
    logic [2*W-1:0] sprod[2];
    int  nacc, nprod;
    bit  switch_pend;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'd12345,      64'h0};
    vecs[3] = '{32'd12345,      32'd0,          64'h0};
    vecs[4] = '{32'd1,          32'd1,          64'h1};
    vecs[5] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[6] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
    vecs[7] = '{32'hDEAD_BEEF,  32'd1,          64'h0000_0000_DEAD_BEEF};
    vecs[8] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
    vecs[9] = '{32'h1234_5678,  32'h0000_0100,  64'h0000_0012_3456_7800};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_op = '0; b_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_product",   product,        64'd0);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, p, lat);
      chk($sformatf("vec%0d_product", i), p, vecs[i].p);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
    end

    // DONE stall: hold out_ready low, offer a new operand pair meanwhile.
    accept_op(32'h1234, 32'h10, ok);
    chk("stall_accept", 64'(ok), 64'd1);
    wait_valid(lat);
    chk("stall_latency", 64'(lat), 64'(LAT));
    in_valid = 1'b1; a_op = 32'hFFFF_FFFF; b_op = 32'h7;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (product !== 64'h12340 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release_in_ready",  64'(in_ready),  64'd1);
    chk("stall_release_out_valid", 64'(out_valid), 64'd0);

    // Reset at ACCUM k=10
    accept_op(32'd100, 32'd200, ok);
    chk("rst_acc_accept", 64'(ok), 64'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_acc_in_ready",  64'(in_ready),  64'd1);
    chk("rst_acc_busy",      64'(busy),      64'd0);
    chk("rst_acc_out_valid", 64'(out_valid), 64'd0);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    chk("rst_acc_no_valid", 64'(bad), 64'd0);
    run_op(32'd7, 32'd9, p, lat);
    chk("rst_acc_followup", p, 64'd63);
    chk("rst_acc_followup_lat", 64'(lat), 64'(LAT));

    // Reset during DONE discards the pending product
    accept_op(32'd11, 32'd13, ok);
    wait_valid(lat);
    chk("rst_done_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_done_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done_product",   product,        64'd0);
    chk("rst_done_in_ready",  64'(in_ready),  64'd1);

    // Streaming: out_ready and in_valid tied high.
    out_ready = 1'b1; in_valid = 1'b1; a_op = 32'd2; b_op = 32'd3;
    nacc = 0; nprod = 0; switch_pend = 1'b0;
    acc_edge[0] = 0; acc_edge[1] = 0; sprod[0] = '0; sprod[1] = '0;
    for (int n = 0; n < 200 && (nacc < 2 || nprod < 2); n++) begin
      if (switch_pend) begin
        switch_pend = 1'b0;
        if (nacc == 1) begin a_op = 32'h8000_0000; b_op = 32'd2; end
        else in_valid = 1'b0;
      end
      if (in_valid && in_ready && nacc < 2) begin
        acc_edge[nacc] = n + 1;
        nacc++;
        switch_pend = 1'b1;
      end
      if (out_valid && nprod < 2) begin
        sprod[nprod] = product;
        nprod++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_count", 64'(nacc * 10 + nprod), 64'd22);
    chk("stream_p0", sprod[0], 64'd6);
    chk("stream_p1", sprod[1], 64'h1_0000_0000);
    // 33 edges to out_valid, one DONE->IDLE edge, then the next acceptance edge:
    // 34 edges strictly between the two acceptance edges.
    chk("stream_gap", 64'(acc_edge[1] - acc_edge[0] - 1), 64'd34);

    // Random run against a native multiply
    for (int r = 0; r < 1500; r++) begin
      ra = $urandom;
      rb = $urandom;
      if (r % 50 == 0) ra = '0;
      if (r % 77 == 0) rb = 32'hFFFF_FFFF;
      exp = {32'b0, ra} * {32'b0, rb};
      run_op(ra, rb, p, lat);
      chk($sformatf("rand%0d_product", r), p, exp);
      chk($sformatf("rand%0d_latency", r), 64'(lat), 64'(LAT));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
